// File: rtl/packed_array_streamer.sv
// Accepts one 4-state packed frame and streams it out as 2-state elements,
// flagging any element that carried x/z bits (per element and sticky per frame).
module packed_array_streamer #(
    parameter int ELEM_W    = 16,
    parameter int NUM_ELEM  = 16,
    parameter int MSB_FIRST = 1,
    parameter int IDX_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1,
    localparam int TOTAL_W  = ELEM_W * NUM_ELEM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ELEM_W-1:0]  out_data,
    output logic               out_xz,
    output logic               out_last,
    output logic [IDX_W-1:0]   out_idx,
    output logic               frame_xz
);

    // state   | meaning
    // S_IDLE   | waiting for a frame, in_ready high once out of reset
    // S_STREAM | presenting element r_idx of the captured frame
    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_alive;
    logic [TOTAL_W-1:0]   r_frame;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                 r_frame_xz;
    logic                 w_accept, w_beat, w_is_last;
    logic [ELEM_W-1:0]    w_elems [NUM_ELEM];
    logic [ELEM_W-1:0]    w_elem, w_elem_2s, w_elem_xz;

    genvar k;
    generate
        for (k = 0; k < NUM_ELEM; k++) begin : g_slice
            if (MSB_FIRST != 0) begin : g_msb
                assign w_elems[k] = r_frame[TOTAL_W-1-k*ELEM_W -: ELEM_W];
            end else begin : g_lsb
                assign w_elems[k] = r_frame[k*ELEM_W +: ELEM_W];
            end
        end
    endgenerate

    assign w_elem = w_elems[r_idx];

    // The frame stays 4-state in r_frame; only known-1 bits survive to out_data.
    always_comb begin
        w_elem_2s = '0;
        w_elem_xz = '0;
        for (int b = 0; b < ELEM_W; b++) begin
            w_elem_2s[b] = (w_elem[b] === 1'b1);
            w_elem_xz[b] = (w_elem[b] !== 1'b0) && (w_elem[b] !== 1'b1);
        end
    end

    assign w_is_last = (r_idx == IDX_W'(NUM_ELEM - 1));
    assign out_valid = (r_state == S_STREAM);
    assign in_ready  = (r_state == S_IDLE) && r_alive;
    assign w_accept  = in_valid && in_ready;
    assign w_beat    = out_valid && out_ready;
    assign out_data  = out_valid ? w_elem_2s : '0;
    assign out_xz    = out_valid && (|w_elem_xz);
    assign out_last  = out_valid && w_is_last;
    assign out_idx   = r_idx;
    assign frame_xz  = r_frame_xz || out_xz;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_STREAM;
                    w_idx_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (w_beat) begin
                    if (w_is_last) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_alive <= 1'b1;
        end
    end

    // Sticky flag survives into IDLE so the consumer can query it after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame    <= '0;
            r_frame_xz <= 1'b0;
        end else if (w_accept) begin
            r_frame    <= in_data;
            r_frame_xz <= 1'b0;
        end else if (out_xz) begin
            r_frame_xz <= 1'b1;
        end
    end

endmodule

// File: tb/tb_packed_array_streamer.sv
// Directed bench for packed_array_streamer: MSB-first and LSB-first instances,
// checked with immediate assertions against hand-built frames.
module tb_packed_array_streamer;
    localparam int EW = 16;
    localparam int NE = 16;
    localparam int TW = EW * NE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_xz, out_last, frame_xz;
    logic [TW-1:0] in_data;
    logic [EW-1:0] out_data;
    logic [3:0]    out_idx;
    logic          in_valid_l, in_ready_l, out_valid_l, out_ready_l, out_xz_l, out_last_l, frame_xz_l;
    logic [TW-1:0] in_data_l;
    logic [EW-1:0] out_data_l;
    logic [3:0]    out_idx_l;

    int total = 0;
    int bad   = 0;

    logic [TW-1:0] fa, fb, fx, fl;
    int            lastc;

    always #5 clk = ~clk;

    packed_array_streamer #(.ELEM_W(EW), .NUM_ELEM(NE), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_xz(out_xz), .out_last(out_last),
        .out_idx(out_idx), .frame_xz(frame_xz)
    );

    packed_array_streamer #(.ELEM_W(EW), .NUM_ELEM(NE), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .in_data(in_data_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
        .out_data(out_data_l), .out_xz(out_xz_l), .out_last(out_last_l),
        .out_idx(out_idx_l), .frame_xz(frame_xz_l)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] elem_of(input logic [TW-1:0] f, input int k);
        elem_of = f[TW-1-k*EW -: EW];
    endfunction

    function automatic logic [EW-1:0] conv(input logic [EW-1:0] e);
        conv = '0;
        for (int b = 0; b < EW; b++) conv[b] = (e[b] === 1'b1);
    endfunction

    function automatic logic isxz(input logic [EW-1:0] e);
        isxz = 1'b0;
        for (int b = 0; b < EW; b++)
            if (e[b] !== 1'b0 && e[b] !== 1'b1) isxz = 1'b1;
    endfunction

    // Called one cycle after the accepting edge; out_ready is low on cycles lo..hi.
    task automatic stream(input logic [TW-1:0] f, input int lo, input int hi, output int last_cycle);
        int   c;
        int   ei;
        logic efx;
        logic [EW-1:0] e;
        c = 1; ei = 0; efx = 1'b0; last_cycle = -1;
        while (ei < NE && c < 60) begin
            out_ready = !(c >= lo && c <= hi);
            e   = elem_of(f, ei);
            efx = efx | isxz(e);
            chk("out_valid", out_valid, 1'b1);
            chk("in_ready_busy", in_ready, 1'b0);
            chk("out_data", out_data, conv(e));
            chk("out_xz", out_xz, isxz(e));
            chk("out_idx", out_idx, ei);
            chk("out_last", out_last, ei == NE - 1);
            chk("frame_xz", frame_xz, efx);
            if (out_ready) begin
                if (ei == NE - 1) last_cycle = c;
                ei++;
            end
            tick();
            c++;
        end
        out_ready = 1'b1;
        chk("beats_done", ei, NE);
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_ready", in_ready, 1'b1);
        chk("idle_last", out_last, 1'b0);
        chk("idle_frame_xz", frame_xz, efx);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid_l = 1'b0; in_data_l = '0; out_ready_l = 1'b1;
        fa = '0; fb = '0; fx = '0; fl = '0;
        for (int k = 0; k < NE; k++) begin
            fa[TW-1-k*EW -: EW] = EW'(k + 1);
            fl[k*EW +: EW]      = EW'(k + 1);
            fb[TW-1-k*EW -: EW] = EW'(16'h0100 + k);
        end
        fx[TW-1-3*EW -: EW] = 16'b0000_0000_0000_xz01;
        fb[TW-1-2*EW -: EW] = 16'hz0x0;

        // reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_idx", out_idx, 4'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_xz", out_xz, 1'b0);
        chk("rst_frame_xz", frame_xz, 1'b0);
        tick();
        chk("rst_hold_ready", in_ready, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_ready_l", in_ready_l, 1'b1);

        // basic frame, no backpressure
        in_valid = 1'b1; in_data = fa;
        tick();
        in_valid = 1'b0;
        stream(fa, 0, -1, lastc);
        chk("basic_last_cycle", lastc, 16);

        // x/z frame: sticky flag through IDLE, cleared on next accept
        in_valid = 1'b1; in_data = fx;
        tick();
        in_valid = 1'b0;
        stream(fx, 0, -1, lastc);
        tick();
        chk("xz_idle_hold", frame_xz, isxz(elem_of(fx, 3)));
        in_valid = 1'b1; in_data = fa;
        tick();
        in_valid = 1'b0;
        chk("xz_cleared", frame_xz, 1'b0);

        // backpressure on cycles 3..5 of the frame just accepted
        stream(fa, 3, 5, lastc);
        chk("bp_last_cycle", lastc, 19);

        // input blocking: B offered continuously while A streams
        in_valid = 1'b1; in_data = fa;
        tick();
        in_data = fb;
        stream(fa, 0, -1, lastc);
        tick();
        in_valid = 1'b0;
        chk("blk_b_valid", out_valid, 1'b1);
        chk("blk_b_data0", out_data, conv(elem_of(fb, 0)));
        chk("blk_b_idx0", out_idx, 4'd0);

        // reset in the middle of frame B at idx 7
        for (int i = 0; i < 7; i++) tick();
        chk("mid_idx", out_idx, 4'd7);
        chk("mid_frame_xz", frame_xz, isxz(elem_of(fb, 2)));
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 1'b0);
        chk("async_idx", out_idx, 4'd0);
        chk("async_frame_xz", frame_xz, 1'b0);
        chk("async_data", out_data, 16'h0000);
        chk("async_ready", in_ready, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_valid", out_valid, 1'b0);
        in_valid = 1'b1; in_data = fa;
        tick();
        in_valid = 1'b0;
        stream(fa, 0, -1, lastc);
        chk("rel_last_cycle", lastc, 16);

        // LSB-first instance
        in_valid_l = 1'b1; in_data_l = fl;
        tick();
        in_valid_l = 1'b0;
        for (int k = 0; k < NE; k++) begin
            chk("lsb_valid", out_valid_l, 1'b1);
            chk("lsb_data", out_data_l, EW'(k + 1));
            chk("lsb_idx", out_idx_l, k);
            chk("lsb_last", out_last_l, k == NE - 1);
            tick();
        end
        chk("lsb_idle", out_valid_l, 1'b0);
        chk("lsb_ready", in_ready_l, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
